weighted_round_robin: RTL and testbench

- Parametrised weighted round-robin arbiter, next generation of the queue-selection arbiter.
- Picks which of QUEUE_QUANTITY output queues is popped each cycle.
- Each queue gets a burst of up to its programmed weight of consecutive pops before service rotates.
- Empty queues are skipped with zero idle cycles; QUEUE_QUANTITY need not be a power of two.

---
 rtl/weighted_round_robin.sv | 138 +++++++++++++
 tb/tb_weighted_round_robin.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/weighted_round_robin.sv
// Weighted round-robin arbiter: picks one non-empty queue per cycle, granting bursts of up to
// each queue's weight. Define WRR_STRICT_Q0_EN to give queue 0 strict priority over the rotation.
module weighted_round_robin #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int WEIGHT_BITS    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enb,
  input  logic [QUEUE_QUANTITY-1:0]             buf_empty,
  input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]     selector,
  output logic                                  out_enb,
  output logic                                  burst_last
);

  localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

  if (QUEUE_QUANTITY < 2 || DATA_BITS < 1 || WEIGHT_BITS < 1) begin : g_param_check
    $error("weighted_round_robin: illegal parameterisation");
  end

  logic [SEL_BITS-1:0]       ptr_q, ptr_d;
  logic [WEIGHT_BITS-1:0]    credit_q, credit_d;
  logic [QUEUE_QUANTITY-1:0] elig_s;
  logic [SEL_BITS-1:0]       cand_s;
  logic [SEL_BITS-1:0]       hit_s;
  logic                      found_s;
  logic [WEIGHT_BITS-1:0]    w_raw_s;
  logic [WEIGHT_BITS-1:0]    w_eff_s;
  logic [SEL_BITS-1:0]       sel_s;
  logic                      oe_s;
  logic                      bl_s;

  // Index arithmetic modulo QUEUE_QUANTITY without relying on power-of-two wrap.
  function automatic logic [SEL_BITS-1:0] wrap_add(input logic [SEL_BITS-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= QUEUE_QUANTITY) begin
      s = s - QUEUE_QUANTITY;
    end else begin
      s = s;
    end
    return SEL_BITS'(s);
  endfunction

  // Queues that may take part in the rotating search.
  always_comb begin
`ifdef WRR_STRICT_Q0_EN
    elig_s = ~buf_empty & ~{{(QUEUE_QUANTITY-1){1'b0}}, 1'b1};
`else
    elig_s = ~buf_empty;
`endif
  end

  // First eligible queue after ptr, wrapping and ending at ptr itself; descending scan so the nearest wins.
  always_comb begin
    found_s = 1'b0;
    hit_s   = ptr_q;
    cand_s  = ptr_q;
    for (int k = QUEUE_QUANTITY; k >= 1; k--) begin
      cand_s = wrap_add(ptr_q, k);
      if (elig_s[cand_s]) begin
        found_s = 1'b1;
        hit_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Burst length loaded for the searched queue; a zero field still grants one pop.
  always_comb begin
    w_raw_s = weights[hit_s*WEIGHT_BITS +: WEIGHT_BITS];
    if (w_raw_s == '0) begin
      w_eff_s = WEIGHT_BITS'(1);
    end else begin
      w_eff_s = w_raw_s;
    end
  end

  // Grant decision and next state.
  always_comb begin
    sel_s    = ptr_q;
    oe_s     = 1'b0;
    bl_s     = 1'b0;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (!enb) begin
      ptr_d    = ptr_q;
`ifdef WRR_STRICT_Q0_EN
    end else if (!buf_empty[0]) begin
      oe_s  = 1'b1;
      sel_s = '0;
      bl_s  = 1'b0;
`endif
    end else if (!buf_empty[ptr_q] && (credit_q != '0)) begin
      oe_s     = 1'b1;
      sel_s    = ptr_q;
      bl_s     = (credit_q == WEIGHT_BITS'(1));
      credit_d = credit_q - WEIGHT_BITS'(1);
    end else if (found_s) begin
      oe_s     = 1'b1;
      sel_s    = hit_s;
      bl_s     = (w_eff_s == WEIGHT_BITS'(1));
      ptr_d    = hit_s;
      credit_d = w_eff_s - WEIGHT_BITS'(1);
    end else begin
      credit_d = '0;
    end
  end

  // Arbitration state; reset points at the last queue so the first search begins at queue 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= SEL_BITS'(QUEUE_QUANTITY - 1);
      credit_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // Outputs are forced low as soon as reset asserts, without waiting for a clock.
  always_comb begin
    if (!rst) begin
      selector   = '0;
      out_enb    = 1'b0;
      burst_last = 1'b0;
    end else begin
      selector   = sel_s;
      out_enb    = oe_s;
      burst_last = bl_s;
    end
  end

endmodule

// File: tb/tb_weighted_round_robin.sv
// Scoreboard bench for weighted_round_robin: a 4-queue instance (weights 2,1,3,1) and a 3-queue
// instance with all-zero weights, checked against hand-computed grant sequences.
module tb_weighted_round_robin;

  typedef struct {
    logic       oe;
    logic [1:0] sel;
    logic       bl;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [3:0] be;
  logic [11:0] w4;
  logic [1:0] sel4;
  logic       oe4, bl4;
  logic       enb3;
  logic [2:0] be3;
  logic [8:0] w3;
  logic [1:0] sel3;
  logic       oe3, bl3;

  exp_t q4[$];
  exp_t q3[$];
  int total = 0;
  int bad = 0;
  int vec = 0;

  always #5 clk = ~clk;

  weighted_round_robin #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .WEIGHT_BITS(3)) dut4 (
    .clk(clk), .rst(rst), .enb(enb), .buf_empty(be), .weights(w4),
    .selector(sel4), .out_enb(oe4), .burst_last(bl4));

  weighted_round_robin #(.QUEUE_QUANTITY(3), .DATA_BITS(8), .WEIGHT_BITS(3)) dut3 (
    .clk(clk), .rst(rst), .enb(enb3), .buf_empty(be3), .weights(w3),
    .selector(sel3), .out_enb(oe3), .burst_last(bl3));

  // Monitor for the 4-queue instance.
  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      total++;
      if ({oe4, sel4, bl4} !== {e.oe, e.sel, e.bl}) begin
        bad++;
        $display("FAIL q4_vec%0d: got oe=%b sel=%0d bl=%b, want oe=%b sel=%0d bl=%b",
                 e.id, oe4, sel4, bl4, e.oe, e.sel, e.bl);
      end
    end
  end

  // Monitor for the 3-queue instance.
  always @(negedge clk) begin
    exp_t e;
    if (q3.size() > 0) begin
      e = q3.pop_front();
      total++;
      if ({oe3, sel3, bl3} !== {e.oe, e.sel, e.bl}) begin
        bad++;
        $display("FAIL q3_vec%0d: got oe=%b sel=%0d bl=%b, want oe=%b sel=%0d bl=%b",
                 e.id, oe3, sel3, bl3, e.oe, e.sel, e.bl);
      end
    end
  end

  task automatic step4(input logic r, input logic en, input logic [3:0] b,
                       input logic xoe, input logic [1:0] xsel, input logic xbl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; enb = en; be = b;
    vec++;
    e.oe = xoe; e.sel = xsel; e.bl = xbl; e.id = vec;
    q4.push_back(e);
  endtask

  task automatic step3(input logic [2:0] b, input logic xoe, input logic [1:0] xsel, input logic xbl);
    exp_t e;
    @(posedge clk);
    #1;
    enb3 = 1'b1; be3 = b;
    vec++;
    e.oe = xoe; e.sel = xsel; e.bl = xbl; e.id = vec;
    q3.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; enb = 1'b0; be = 4'b1111;
    w4 = {3'd1, 3'd3, 3'd1, 3'd2};
    enb3 = 1'b0; be3 = 3'b111; w3 = 9'd0;
    // reset state
    step4(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    // steady rotation
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
    // enb gap after first pop of q2's burst
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
    step4(1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
    step4(1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1);
    // sole non-empty queue, then all empty
    step4(1'b1, 1'b1, 4'b1011, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b1011, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b1011, 1'b1, 2'd2, 1'b1);
    step4(1'b1, 1'b1, 4'b1011, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b1011, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b1011, 1'b1, 2'd2, 1'b1);
    step4(1'b1, 1'b1, 4'b1111, 1'b0, 2'd2, 1'b0);
    // skip and forfeit
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1);
    step4(1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
    step4(1'b1, 1'b1, 4'b0011, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b0011, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b1, 4'b0011, 1'b1, 2'd2, 1'b1);
    step4(1'b1, 1'b1, 4'b0011, 1'b1, 2'd3, 1'b1);
    step4(1'b1, 1'b1, 4'b0011, 1'b1, 2'd2, 1'b0);
    // asynchronous reset mid-burst, sampled before the next clock edge
    step4(1'b0, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0);
    step4(1'b0, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0);
    step4(1'b1, 1'b1, 4'b1001, 1'b1, 2'd1, 1'b1);
    step4(1'b1, 1'b1, 4'b1001, 1'b1, 2'd2, 1'b0);
    step4(1'b1, 1'b0, 4'b1001, 1'b0, 2'd2, 1'b0);
    // zero weights on three queues
    step3(3'b000, 1'b1, 2'd0, 1'b1);
    step3(3'b000, 1'b1, 2'd1, 1'b1);
    step3(3'b000, 1'b1, 2'd2, 1'b1);
    step3(3'b000, 1'b1, 2'd0, 1'b1);
    step3(3'b000, 1'b1, 2'd1, 1'b1);
    step3(3'b000, 1'b1, 2'd2, 1'b1);
    step3(3'b010, 1'b1, 2'd0, 1'b1);
    step3(3'b010, 1'b1, 2'd2, 1'b1);
    repeat (4) @(posedge clk);
    total++;
    if (q4.size() + q3.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q4.size() + q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
